// File: rtl/pong_key_arbiter.sv
// Keyboard keycode to per-player paddle commands and serve strobe, published on frame_tick.
// Optional KEY_STATS_EN adds last_key / press_count debug outputs.
module pong_key_arbiter #(
    parameter int          HOLD_CYCLES = 2500000,
    parameter logic [7:0]  P1_UP_KEY   = 8'h1A,
    parameter logic [7:0]  P1_DN_KEY   = 8'h16,
    parameter logic [7:0]  P2_UP_KEY   = 8'h52,
    parameter logic [7:0]  P2_DN_KEY   = 8'h51,
    parameter logic [7:0]  SERVE_KEY   = 8'h2C
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       frame_tick,
    output logic       p1_up,
    output logic       p1_dn,
    output logic       p2_up,
    output logic       p2_dn,
    output logic       serve_pulse
`ifdef KEY_STATS_EN
    ,
    output logic [7:0] last_key,
    output logic [7:0] press_count
`endif
);

    localparam int CW = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

    // state | meaning
    // IDLE  | no command held
    // UP    | up command held, counter running
    // DN    | down command held, counter running
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_DN   = 2'd2;

    logic [7:0]    key_q;
    logic [1:0]    p1_st_q, p1_st_d, p2_st_q, p2_st_d;
    logic [CW-1:0] p1_cnt_q, p1_cnt_d, p2_cnt_q, p2_cnt_d;
    logic          p1_up_q, p1_dn_q, p2_up_q, p2_dn_q;
    logic          serve_req_q, serve_req_d, prev_serve_q, serve_pulse_q, serve_pulse_d;
    logic          is_serve, serve_seen;

    // Latest key wins; a hit always reloads the hold window.
    function automatic logic [CW+1:0] fsm_next(input logic [1:0] st, input logic [CW-1:0] cnt,
                                               input logic hit_up, input logic hit_dn);
        if (hit_up)
            return {S_UP, CNT_LOAD};
        else if (hit_dn)
            return {S_DN, CNT_LOAD};
        else if (st == S_IDLE || cnt == {CW{1'b0}})
            return {S_IDLE, {CW{1'b0}}};
        else
            return {st, cnt - 1'b1};
    endfunction

    always_comb begin
        {p1_st_d, p1_cnt_d} = fsm_next(p1_st_q, p1_cnt_q, key_q == P1_UP_KEY, key_q == P1_DN_KEY);
        {p2_st_d, p2_cnt_d} = fsm_next(p2_st_q, p2_cnt_q, key_q == P2_UP_KEY, key_q == P2_DN_KEY);
    end

    // A press coinciding with a tick is consumed by that tick.
    always_comb begin
        is_serve      = (key_q == SERVE_KEY);
        serve_seen    = is_serve && !prev_serve_q;
        serve_pulse_d = frame_tick && (serve_req_q || serve_seen);
        serve_req_d   = frame_tick ? 1'b0 : (serve_req_q || serve_seen);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_q         <= 8'h00;
            p1_st_q       <= S_IDLE;
            p2_st_q       <= S_IDLE;
            p1_cnt_q      <= '0;
            p2_cnt_q      <= '0;
            p1_up_q       <= 1'b0;
            p1_dn_q       <= 1'b0;
            p2_up_q       <= 1'b0;
            p2_dn_q       <= 1'b0;
            serve_req_q   <= 1'b0;
            prev_serve_q  <= 1'b0;
            serve_pulse_q <= 1'b0;
        end else begin
            key_q         <= keycode;
            p1_st_q       <= p1_st_d;
            p2_st_q       <= p2_st_d;
            p1_cnt_q      <= p1_cnt_d;
            p2_cnt_q      <= p2_cnt_d;
            serve_req_q   <= serve_req_d;
            prev_serve_q  <= is_serve;
            serve_pulse_q <= serve_pulse_d;
            if (frame_tick) begin
                p1_up_q <= (p1_st_q == S_UP);
                p1_dn_q <= (p1_st_q == S_DN);
                p2_up_q <= (p2_st_q == S_UP);
                p2_dn_q <= (p2_st_q == S_DN);
            end
        end
    end

    assign p1_up       = p1_up_q;
    assign p1_dn       = p1_dn_q;
    assign p2_up       = p2_up_q;
    assign p2_dn       = p2_dn_q;
    assign serve_pulse = serve_pulse_q;

`ifdef KEY_STATS_EN
    logic [7:0] key_prev_q, last_key_q, press_count_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_prev_q    <= 8'h00;
            last_key_q    <= 8'h00;
            press_count_q <= 8'h00;
        end else begin
            key_prev_q <= key_q;
            if (key_q != 8'h00)
                last_key_q <= key_q;
            if (key_q != 8'h00 && key_prev_q == 8'h00)
                press_count_q <= press_count_q + 8'd1;
        end
    end

    assign last_key    = last_key_q;
    assign press_count = press_count_q;
`endif

endmodule

// File: tb/tb_pong_key_arbiter.sv
// Randomized and directed bench for pong_key_arbiter against a hold-window reference model.
module tb_pong_key_arbiter;

    localparam int HOLD = 8;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] keycode = 8'h00;
    logic       frame_tick = 1'b0;
    logic       p1_up, p1_dn, p2_up, p2_dn, serve_pulse;
`ifdef KEY_STATS_EN
    logic [7:0] last_key, press_count;
`endif

    pong_key_arbiter #(.HOLD_CYCLES(HOLD)) dut (
        .Clk(Clk), .Reset(Reset), .keycode(keycode), .frame_tick(frame_tick),
        .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
        .serve_pulse(serve_pulse)
`ifdef KEY_STATS_EN
        , .last_key(last_key), .press_count(press_count)
`endif
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Reference model: a player command is the direction of its most recent hit,
    // valid while fewer than HOLD edges have elapsed since that hit.
    int         cyc = 0;
    bit         hv[2];
    int         hit_cyc[2];
    int         hdir[2];       // 1 = up, 2 = down
    logic [7:0] m_kq;
    bit         m_prev_s, m_req;
    bit         m_p1u, m_p1d, m_p2u, m_p2d, m_pulse;
    logic [7:0] m_kprev, m_last, m_cnt;
    int         pulses;

    function automatic int state_at(int p, int n);
        if (hv[p] && (n - hit_cyc[p]) < HOLD) return hdir[p];
        return 0;
    endfunction

    task automatic model_edge(input logic [7:0] k, input bit t, input bit r);
        int s1, s2;
        bit is_s, seen;
        if (r) begin
            hv[0] = 0; hv[1] = 0;
            m_kq = 8'h00; m_prev_s = 0; m_req = 0; m_pulse = 0;
            m_p1u = 0; m_p1d = 0; m_p2u = 0; m_p2d = 0;
            m_kprev = 8'h00; m_last = 8'h00; m_cnt = 8'h00;
            return;
        end
        s1 = state_at(0, cyc - 1);
        s2 = state_at(1, cyc - 1);
        if (t) begin
            m_p1u = (s1 == 1); m_p1d = (s1 == 2);
            m_p2u = (s2 == 1); m_p2d = (s2 == 2);
        end
        is_s    = (m_kq == 8'h2C);
        seen    = is_s && !m_prev_s;
        m_pulse = t && (m_req || seen);
        m_req   = t ? 1'b0 : (m_req || seen);
        m_prev_s = is_s;
        case (m_kq)
            8'h1A: begin hv[0] = 1; hit_cyc[0] = cyc; hdir[0] = 1; end
            8'h16: begin hv[0] = 1; hit_cyc[0] = cyc; hdir[0] = 2; end
            8'h52: begin hv[1] = 1; hit_cyc[1] = cyc; hdir[1] = 1; end
            8'h51: begin hv[1] = 1; hit_cyc[1] = cyc; hdir[1] = 2; end
            default: ;
        endcase
        if (m_kq != 8'h00) begin
            m_last = m_kq;
            if (m_kprev == 8'h00) m_cnt = m_cnt + 8'd1;
        end
        m_kprev = m_kq;
        m_kq = k;
    endtask

    task automatic step(input logic [7:0] k, input bit t, input bit r);
        keycode = k; frame_tick = t; Reset = r;
        @(posedge Clk);
        cyc++;
        model_edge(k, t, r);
        #1;
        chk("p1_up", p1_up, m_p1u);
        chk("p1_dn", p1_dn, m_p1d);
        chk("p2_up", p2_up, m_p2u);
        chk("p2_dn", p2_dn, m_p2d);
        chk("serve_pulse", serve_pulse, m_pulse);
        if (serve_pulse) pulses++;
`ifdef KEY_STATS_EN
        chk("last_key", last_key, m_last);
        chk("press_count", press_count, m_cnt);
`endif
    endtask

    logic [7:0] keys[7];

    initial begin
        keys[0] = 8'h00; keys[1] = 8'h1A; keys[2] = 8'h16; keys[3] = 8'h52;
        keys[4] = 8'h51; keys[5] = 8'h2C; keys[6] = 8'h04;

        // Reset coincident with a hit key and a tick
        step(8'h1A, 1, 1);
        chk("rst_all_zero", {p1_up, p1_dn, p2_up, p2_dn, serve_pulse}, 5'b0);
        step(8'h1A, 0, 0);
        step(8'h00, 0, 0);
        step(8'h00, 1, 0);
        chk("after_rst_p1_up", p1_up, 1'b1);

        // Single press, ticks every 4 cycles: hold window then release
        step(8'h00, 0, 1);
        step(8'h1A, 0, 0);
        for (int i = 0; i < 24; i++) step(8'h00, (i % 4) == 3, 0);
        chk("hold_released", p1_up, 1'b0);

        // Opposite direction preempts immediately
        step(8'h00, 0, 1);
        step(8'h1A, 0, 0);
        step(8'h16, 0, 0);
        step(8'h00, 0, 0);
        step(8'h00, 1, 0);
        chk("preempt_dn", {p1_up, p1_dn}, 2'b01);

        // Time-sharing between players
        step(8'h00, 0, 1);
        for (int i = 0; i < 10; i++) step((i % 2) ? 8'h52 : 8'h1A, 0, 0);
        step(8'h00, 1, 0);
        chk("shared_up", {p1_up, p1_dn, p2_up, p2_dn}, 4'b1010);

        // Held Space gives one pulse; a fresh press gives another
        step(8'h00, 0, 1);
        pulses = 0;
        for (int i = 0; i < 20; i++) step(8'h2C, (i % 6) == 5, 0);
        chk("serve_once", pulses, 1);
        step(8'h00, 0, 0);
        step(8'h2C, 0, 0);
        for (int i = 0; i < 4; i++) step(8'h00, i == 2, 0);
        chk("serve_twice", pulses, 2);

`ifdef KEY_STATS_EN
        step(8'h00, 0, 1);
        step(8'h00, 0, 0); step(8'h1A, 0, 0); step(8'h00, 0, 0);
        step(8'h1A, 0, 0); step(8'h16, 0, 0); step(8'h00, 0, 0);
        step(8'h00, 0, 0); step(8'h00, 0, 0);
        chk("stats_count", press_count, 8'd2);
        chk("stats_last", last_key, 8'h16);
        for (int i = 0; i < 256; i++) begin
            step(8'h1A, 0, 0);
            step(8'h00, 0, 0);
        end
        step(8'h00, 0, 0);
        chk("stats_wrap", press_count, 8'd2);
`endif

        // Randomized traffic with occasional mid-run resets
        for (int i = 0; i < 3000; i++) begin
            step(keys[$urandom_range(0, 6)], $urandom_range(0, 3) == 0,
                 $urandom_range(0, 299) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
